// File: rtl/rr_arbiter4_pkg.sv
// rr_arbiter4_pkg
// Shared constants and helpers for the four-requester round-robin arbiter.
//   - FSM state encoding (IDLE / BUSY)
//   - requester count and index width
//   - hold counter width
//   - idToOneHot(): binary client index to one-hot request vector
package rr_arbiter4_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned ID_W   = 2;
    localparam int unsigned HCNT_W = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef logic [N_REQ-1:0]  req_t;
    typedef logic [ID_W-1:0]   id_t;
    typedef logic [HCNT_W-1:0] hcnt_t;

    function automatic req_t idToOneHot(input id_t id);
        req_t v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if
// Request/grant bundle between the arbiter and its four clients.
//   req   : per-client level request (clients -> arbiter)
//   gnt   : registered one-hot grant (arbiter -> clients)
//   gntId : binary index of the granted client, 0 when idle
//   valid : high exactly when gnt is non-zero
// Modports:
//   master : arbiter side (drives the grant)
//   slave  : client side (drives the requests)
interface rr_arbiter4_if;
    import rr_arbiter4_pkg::*;

    req_t req;
    req_t gnt;
    id_t  gntId;
    logic valid;

    modport master (
        input  req,
        output gnt,
        output gntId,
        output valid
    );

    modport slave (
        output req,
        input  gnt,
        input  gntId,
        input  valid
    );

endinterface

// File: rtl/rr_arbiter4_pick4.sv
// rr_pick4
// Combinational round-robin pick over four requests.
// The search starts at client pri_i and proceeds pri_i+1, +2, +3 (mod 4);
// clients with their mask_i bit set are never picked.
// Ports:
//   req_i    [3:0] raw requests
//   pri_i    [1:0] first client to consider
//   mask_i   [3:0] clients excluded from this pick
//   any_o          some unmasked client is requesting
//   winId_o  [1:0] binary index of the winner (0 when none)
//   winOh_o  [3:0] one-hot winner (0 when none)
module rr_pick4
    import rr_arbiter4_pkg::*;
(
    input  req_t req_i,
    input  id_t  pri_i,
    input  req_t mask_i,
    output logic any_o,
    output id_t  winId_o,
    output req_t winOh_o
);

    req_t              effReq;
    logic [2*N_REQ-1:0] rotWide;
    req_t              rotReq;
    req_t              isoReq;
    logic [2*N_REQ-1:0] backWide;

    assign effReq = req_i & ~mask_i;
    assign any_o  = |effReq;

    // Rotate right by pri_i so client pri_i lands in bit 0; doubling the
    // vector makes the shift wrap around.
    assign rotWide = {effReq, effReq} >> pri_i;
    assign rotReq  = rotWide[N_REQ-1:0];

    // Lowest set bit of the rotated vector is the first requester found.
    assign isoReq = rotReq & ~(rotReq - req_t'(1));

    // Rotate back left by pri_i; the upper half of the doubled vector
    // holds the wrapped result.
    assign backWide = {isoReq, isoReq} << pri_i;
    assign winOh_o  = backWide[2*N_REQ-1:N_REQ];

    // One-hot to binary; winOh_o has at most one bit set.
    always_comb begin
        winId_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winOh_o[i]) begin
                winId_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4
// Four-requester round-robin arbiter with grant locking and an optional
// hold limit. A granted client keeps the resource while its request stays
// high; on release the next requester is granted on the same edge. With a
// non-zero HOLD_LIMIT a holder is forced to yield after HOLD_LIMIT
// consecutive cycles if another client is waiting.
// Parameters:
//   HOLD_LIMIT : max consecutive grant cycles per holder, 0 = unlimited (0..255)
// Ports:
//   clk_i : system clock, all state on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : request/grant bundle (master side)
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int unsigned HOLD_LIMIT = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rr_arbiter4_if.master bus
);

    localparam hcnt_t HOLD_LIM = HCNT_W'(HOLD_LIMIT);

    logic [0:0] state_q, state_d;
    id_t        pri_q, pri_d;
    id_t        cur_q, cur_d;
    hcnt_t      holdCnt_q, holdCnt_d;
    req_t       gnt_q, gnt_d;
    id_t        gntId_q, gntId_d;
    logic       valid_q, valid_d;

    logic       holding;
    logic       limitHit;
    req_t       pickMask;
    logic       pickAny;
    id_t        pickId;
    req_t       pickOh;

    // The holder still wants the resource; only meaningful in BUSY.
    assign holding  = (state_q == ST_BUSY) && bus.req[cur_q];
    assign limitHit = (HOLD_LIM != '0) && (holdCnt_q == HOLD_LIM);

    // During a forced rotation the current holder must not win again
    // unless nobody else asks, so it is masked out of the single pick.
    assign pickMask = (holding && limitHit) ? idToOneHot(cur_q) : '0;

    rr_pick4 u_pick (
        .req_i   (bus.req),
        .pri_i   (pri_q),
        .mask_i  (pickMask),
        .any_o   (pickAny),
        .winId_o (pickId),
        .winOh_o (pickOh)
    );

    // Next-state logic. PRI moves only when a new grant is issued, so the
    // search start stays fair no matter how long a holder kept the grant.
    always_comb begin
        state_d   = state_q;
        pri_d     = pri_q;
        cur_d     = cur_q;
        holdCnt_d = holdCnt_q;
        gnt_d     = gnt_q;
        gntId_d   = gntId_q;
        valid_d   = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (pickAny) begin
                    state_d   = ST_BUSY;
                    cur_d     = pickId;
                    pri_d     = pickId + 1'b1;
                    holdCnt_d = hcnt_t'(1);
                    gnt_d     = pickOh;
                    gntId_d   = pickId;
                    valid_d   = 1'b1;
                end else begin
                    gnt_d   = '0;
                    gntId_d = '0;
                    valid_d = 1'b0;
                end
            end

            ST_BUSY: begin
                if (!holding) begin
                    // Released: hand over on this edge, or fall idle.
                    if (pickAny) begin
                        cur_d     = pickId;
                        pri_d     = pickId + 1'b1;
                        holdCnt_d = hcnt_t'(1);
                        gnt_d     = pickOh;
                        gntId_d   = pickId;
                        valid_d   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        gntId_d = '0;
                        valid_d = 1'b0;
                    end
                end else if (!limitHit) begin
                    // Locked hold; counter saturates instead of wrapping.
                    if (holdCnt_q != '1) begin
                        holdCnt_d = holdCnt_q + 1'b1;
                    end
                end else if (pickAny) begin
                    // Budget exhausted and someone else is waiting.
                    cur_d     = pickId;
                    pri_d     = pickId + 1'b1;
                    holdCnt_d = hcnt_t'(1);
                    gnt_d     = pickOh;
                    gntId_d   = pickId;
                    valid_d   = 1'b1;
                end else begin
                    // Budget exhausted but alone: start a fresh budget.
                    holdCnt_d = hcnt_t'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                gntId_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides every transition.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pri_q     <= '0;
            cur_q     <= '0;
            holdCnt_q <= '0;
            gnt_q     <= '0;
            gntId_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pri_q     <= pri_d;
            cur_q     <= cur_d;
            holdCnt_q <= holdCnt_d;
            gnt_q     <= gnt_d;
            gntId_q   <= gntId_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.gntId = gntId_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4
// Drives one request stream into two arbiters (HOLD_LIMIT=0 and 3) and
// checks both every cycle against a behavioural model, plus hand-computed
// expectations at key points of the directed sequence.
module tb_rr_arbiter4;

    logic       clk;
    logic       rstDrv;
    logic [3:0] reqDrv;

    int vecCount;
    int missCount;
    int cycleNo;

    // Model state per arbiter: index 0 = unlimited hold, 1 = limit 3.
    int  mLimit [2];
    bit  mBusy  [2];
    int  mPri   [2];
    int  mCur   [2];
    int  mHcnt  [2];
    bit  modelReady;

    rr_arbiter4_if busA ();
    rr_arbiter4_if busB ();

    assign busA.req = reqDrv;
    assign busB.req = reqDrv;

    rr_arbiter4 #(.HOLD_LIMIT(0)) dutA (
        .clk_i (clk),
        .rst_i (rstDrv),
        .bus   (busA)
    );

    rr_arbiter4 #(.HOLD_LIMIT(3)) dutB (
        .clk_i (clk),
        .rst_i (rstDrv),
        .bus   (busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First requester found scanning start, start+1, ... mod 4, skipping excl.
    function automatic int modelPick(input logic [3:0] r, input int start, input int excl);
        for (int i = 0; i < 4; i++) begin
            int j;
            j = (start + i) % 4;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    // Behavioural model: advance each arbiter by one clock edge.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int w;
            if (rstDrv) begin
                mBusy[m] = 1'b0;
                mPri[m]  = 0;
                mCur[m]  = 0;
                mHcnt[m] = 0;
            end else if (!mBusy[m] || !reqDrv[mCur[m]]) begin
                w = modelPick(reqDrv, mPri[m], -1);
                if (w >= 0) begin
                    mBusy[m] = 1'b1;
                    mCur[m]  = w;
                    mPri[m]  = (w + 1) % 4;
                    mHcnt[m] = 1;
                end else begin
                    mBusy[m] = 1'b0;
                end
            end else if (mLimit[m] == 0 || mHcnt[m] < mLimit[m]) begin
                if (mHcnt[m] < 255) mHcnt[m] = mHcnt[m] + 1;
            end else begin
                w = modelPick(reqDrv, mPri[m], mCur[m]);
                if (w >= 0) begin
                    mCur[m]  = w;
                    mPri[m]  = (w + 1) % 4;
                    mHcnt[m] = 1;
                end else begin
                    mHcnt[m] = 1;
                end
            end
        end
        if (rstDrv) modelReady = 1'b1;
        cycleNo++;
    end

    // Per-cycle comparison of both arbiters against the model.
    always @(negedge clk) begin
        if (modelReady) begin
            for (int m = 0; m < 2; m++) begin
                logic [3:0] expGnt, actGnt;
                logic [1:0] expId, actId;
                logic       expValid, actValid;
                expGnt   = mBusy[m] ? (4'b0001 << mCur[m]) : 4'b0000;
                expId    = mBusy[m] ? 2'(mCur[m]) : 2'd0;
                expValid = mBusy[m];
                actGnt   = (m == 0) ? busA.gnt   : busB.gnt;
                actId    = (m == 0) ? busA.gntId : busB.gntId;
                actValid = (m == 0) ? busA.valid : busB.valid;
                vecCount++;
                if (actGnt !== expGnt || actId !== expId || actValid !== expValid) begin
                    missCount++;
                    $display("[TB] FAIL model dut%0d cycle %0d: got gnt=%b id=%0d valid=%b, want gnt=%b id=%0d valid=%b",
                             m, cycleNo, actGnt, actId, actValid, expGnt, expId, expValid);
                end
            end
        end
    end

    // Drive inputs just after a rising edge and hold them for n edges.
    task automatic applyStimulus(input logic [3:0] r, input logic rs, input int n);
        reqDrv = r;
        rstDrv = rs;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare one arbiter's outputs against a hand-computed grant.
    task automatic checkOutput(input string name, input int dut, input logic [3:0] expGnt, input logic [1:0] expId);
        logic [3:0] actGnt;
        logic [1:0] actId;
        logic       actValid;
        logic       expValid;
        expValid = (expGnt != 4'b0000);
        actGnt   = (dut == 0) ? busA.gnt   : busB.gnt;
        actId    = (dut == 0) ? busA.gntId : busB.gntId;
        actValid = (dut == 0) ? busA.valid : busB.valid;
        vecCount++;
        if (actGnt !== expGnt || actId !== expId || actValid !== expValid) begin
            missCount++;
            $display("[TB] FAIL %s dut%0d: got gnt=%b id=%0d valid=%b, want gnt=%b id=%0d valid=%b",
                     name, dut, actGnt, actId, actValid, expGnt, expId, expValid);
        end
    endtask

    initial begin
        vecCount   = 0;
        missCount  = 0;
        cycleNo    = 0;
        modelReady = 1'b0;
        mLimit[0]  = 0;
        mLimit[1]  = 3;
        for (int m = 0; m < 2; m++) begin
            mBusy[m] = 1'b0;
            mPri[m]  = 0;
            mCur[m]  = 0;
            mHcnt[m] = 0;
        end
        reqDrv = 4'b0000;
        rstDrv = 1'b1;

        // Reset, then a single request from client 2.
        applyStimulus(4'b0000, 1'b1, 1);
        checkOutput("reset", 0, 4'b0000, 2'd0);
        checkOutput("reset", 1, 4'b0000, 2'd0);
        applyStimulus(4'b0100, 1'b0, 1);
        checkOutput("single_req", 0, 4'b0100, 2'd2);
        checkOutput("single_req", 1, 4'b0100, 2'd2);
        applyStimulus(4'b0000, 1'b0, 1);
        checkOutput("release_idle", 0, 4'b0000, 2'd0);
        checkOutput("release_idle", 1, 4'b0000, 2'd0);

        // Rotation: each holder drops its request right after being granted.
        applyStimulus(4'b0000, 1'b1, 1);
        applyStimulus(4'b1111, 1'b0, 1);
        checkOutput("rot0", 0, 4'b0001, 2'd0);
        applyStimulus(4'b1110, 1'b0, 1);
        checkOutput("rot1", 0, 4'b0010, 2'd1);
        applyStimulus(4'b1101, 1'b0, 1);
        checkOutput("rot2", 0, 4'b0100, 2'd2);
        applyStimulus(4'b1011, 1'b0, 1);
        checkOutput("rot3", 0, 4'b1000, 2'd3);
        applyStimulus(4'b0111, 1'b0, 1);
        checkOutput("rot4", 0, 4'b0001, 2'd0);

        // Pointer start: client 1 granted (PRI=2), idle, then 0011 -> client 0.
        applyStimulus(4'b0010, 1'b0, 1);
        checkOutput("grant1", 0, 4'b0010, 2'd1);
        applyStimulus(4'b0000, 1'b0, 1);
        applyStimulus(4'b0011, 1'b0, 1);
        checkOutput("ptr_start", 0, 4'b0001, 2'd0);
        checkOutput("ptr_start", 1, 4'b0001, 2'd0);

        // Lock vs hold limit: client 1 granted from idle with all requesting.
        applyStimulus(4'b0000, 1'b0, 1);
        applyStimulus(4'b1111, 1'b0, 1);
        checkOutput("lock_e1", 0, 4'b0010, 2'd1);
        checkOutput("limit_e1", 1, 4'b0010, 2'd1);
        applyStimulus(4'b1111, 1'b0, 2);
        checkOutput("limit_e3", 1, 4'b0010, 2'd1);
        applyStimulus(4'b1111, 1'b0, 1);
        checkOutput("limit_e4", 1, 4'b0100, 2'd2);
        applyStimulus(4'b1111, 1'b0, 3);
        checkOutput("limit_e7", 1, 4'b1000, 2'd3);
        applyStimulus(4'b1111, 1'b0, 3);
        checkOutput("limit_e10", 1, 4'b0001, 2'd0);
        applyStimulus(4'b1111, 1'b0, 10);
        checkOutput("lock_e20", 0, 4'b0010, 2'd1);
        checkOutput("limit_e20", 1, 4'b1000, 2'd3);

        // Reset mid-grant, then 1001 from PRI=0 -> client 0.
        applyStimulus(4'b1111, 1'b1, 1);
        checkOutput("rst_mid", 0, 4'b0000, 2'd0);
        checkOutput("rst_mid", 1, 4'b0000, 2'd0);
        applyStimulus(4'b1001, 1'b0, 1);
        checkOutput("after_rst", 0, 4'b0001, 2'd0);
        checkOutput("after_rst", 1, 4'b0001, 2'd0);

        // Lone requester keeps the grant past the limit and past counter saturation.
        applyStimulus(4'b0001, 1'b0, 10);
        checkOutput("alone_limit", 1, 4'b0001, 2'd0);
        applyStimulus(4'b0001, 1'b0, 260);
        checkOutput("alone_sat", 0, 4'b0001, 2'd0);
        checkOutput("alone_sat", 1, 4'b0001, 2'd0);

        // Handover straight from a long hold to client 3.
        applyStimulus(4'b1000, 1'b0, 1);
        checkOutput("handover", 0, 4'b1000, 2'd3);
        checkOutput("handover", 1, 4'b1000, 2'd3);
        applyStimulus(4'b0000, 1'b0, 2);
        checkOutput("final_idle", 0, 4'b0000, 2'd0);
        checkOutput("final_idle", 1, 4'b0000, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
